// File: rtl/mole_game_core.sv
// mole_game_core: parametrised whack-a-mole game engine.
// Sits between the keypad controller (one-hot key pulses, start level) and the
// LED / 7-segment controller (one-hot lit hole, remaining seconds, score).
// A game runs for GAME_SECONDS one-second ticks. Moles appear after a blank gap
// at a pseudo-random hole and escape after a lifetime that halves per level.
// Optional build macro HIGH_SCORE_EN adds output 'best': the highest final score
// since the last reset.

module mole_game_core #(
   parameter int N_HOLES      = 16,
   parameter int SCORE_W      = 5,
   parameter int TIME_W       = 6,
   parameter int GAME_SECONDS = 60,
   parameter int TICK_DIV     = 50000000,
   parameter int MOLE_CYCLES  = 50000000,
   parameter int GAP_CYCLES   = 5000000,
   parameter int LEVEL_STEP   = 4,
   parameter int MAX_LEVEL    = 3,
   parameter int PENALTY      = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_HOLES-1:0] key,
   input  logic               start,
   output logic [N_HOLES-1:0] position,
   output logic [TIME_W-1:0]  cnttime,
   output logic [SCORE_W-1:0] score,
   output logic [1:0]         level,
   output logic               playing,
   output logic               game_over,
   output logic               hit,
   output logic               miss
`ifdef HIGH_SCORE_EN
   ,
   output logic [SCORE_W-1:0] best
`endif
);

   localparam int IDX_W   = (N_HOLES > 1) ? $clog2(N_HOLES) : 1;
   localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int LIFE_W  = $clog2(MOLE_CYCLES + 1);
   localparam int GAP_W   = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

   localparam logic [TIME_W-1:0]  GAME_T    = TIME_W'(GAME_SECONDS);
   localparam logic [PRESC_W-1:0] PRESC_TOP = PRESC_W'(TICK_DIV - 1);
   localparam logic [LIFE_W-1:0]  MOLE_L    = LIFE_W'(MOLE_CYCLES);
   localparam logic [GAP_W-1:0]   GAP_L     = GAP_W'(GAP_CYCLES);
   localparam logic [SCORE_W-1:0] STEP_S    = SCORE_W'(LEVEL_STEP);
   localparam logic [SCORE_W-1:0] MAXL_S    = SCORE_W'(MAX_LEVEL);
   localparam logic [1:0]         MAXL_2    = 2'(MAX_LEVEL);
   localparam logic [15:0]        N_16      = 16'(N_HOLES);
   localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(N_HOLES - 1);
   localparam logic [15:0]        LFSR_SEED = 16'hACE1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PLAY = 2'd1,
      S_OVER = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [15:0]          lfsr_q, lfsr_d;
   logic                 start_q;
   logic [PRESC_W-1:0]   presc_q, presc_d;
   logic [TIME_W-1:0]    time_q, time_d;
   logic [SCORE_W-1:0]   score_q, score_d;
   logic [1:0]           level_q, level_d;
   logic [N_HOLES-1:0]   pos_q, pos_d;
   logic [GAP_W-1:0]     gap_q, gap_d;
   logic [LIFE_W-1:0]    life_q, life_d;
   logic [IDX_W-1:0]     prev_q, prev_d;
   logic                 prev_vld_q, prev_vld_d;
   logic                 hit_q, hit_d;
   logic                 miss_q, miss_d;
`ifdef HIGH_SCORE_EN
   logic [SCORE_W-1:0]   best_q, best_d;
`endif

   logic                 start_rise;
   logic                 tick;
   logic                 game_end;
   logic                 lfsr_fb;
   logic [IDX_W-1:0]     rnd_idx;
   logic [IDX_W-1:0]     next_idx;
   logic [IDX_W-1:0]     sel_idx;
   logic [N_HOLES-1:0]   spawn_hot;
   logic [SCORE_W-1:0]   score_div;
   logic [1:0]           lvl_calc;
   logic [LIFE_W-1:0]    life_load;

   // Shared decode: start edge, second tick, last tick of the game.
   assign start_rise = start & ~start_q;
   assign tick       = (presc_q == PRESC_TOP);
   assign game_end   = (state_q == S_PLAY) && tick && (time_q <= TIME_W'(1));

   // Fibonacci LFSR taps 16,14,13,11 (bit numbering 1..16 -> 15,13,12,10).
   assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

   // Hole choice: LFSR modulo hole count, bumped by one if it repeats the last hole.
   assign rnd_idx  = IDX_W'(lfsr_q % N_16);
   assign next_idx = (rnd_idx == LAST_IDX) ? '0 : rnd_idx + IDX_W'(1);
   assign sel_idx  = (prev_vld_q && (rnd_idx == prev_q)) ? next_idx : rnd_idx;

   generate
      for (genvar gi = 0; gi < N_HOLES; gi++) begin : g_hot
         assign spawn_hot[gi] = (sel_idx == IDX_W'(gi));
      end
   endgenerate

   // Level follows score with one cycle of lag; lifetime uses the current level.
   assign score_div = score_q / STEP_S;
   assign lvl_calc  = (score_div >= MAXL_S) ? MAXL_2 : score_div[1:0];
   assign life_load = MOLE_L >> level_q;

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: start edge enters play, last second tick ends it.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start_rise) state_d = S_PLAY;
         S_PLAY:  if (game_end)   state_d = S_OVER;
         S_OVER:  if (start_rise) state_d = S_PLAY;
         default: state_d = S_IDLE;
      endcase
   end

   // State-decoded status outputs.
   always_comb begin
      playing   = (state_q == S_PLAY);
      game_over = (state_q == S_OVER);
   end

   // Game datapath next-state: timer, gap/mole phases, scoring and pulses.
   always_comb begin
      lfsr_d     = {lfsr_q[14:0], lfsr_fb};
      presc_d    = presc_q;
      time_d     = time_q;
      score_d    = score_q;
      level_d    = lvl_calc;
      pos_d      = pos_q;
      gap_d      = gap_q;
      life_d     = life_q;
      prev_d     = prev_q;
      prev_vld_d = prev_vld_q;
      hit_d      = 1'b0;
      miss_d     = 1'b0;
`ifdef HIGH_SCORE_EN
      best_d     = best_q;
`endif
      case (state_q)
         S_IDLE, S_OVER: begin
            pos_d = '0;
            if (state_q == S_OVER) time_d = '0;
            if (start_rise) begin
               presc_d = '0;
               time_d  = GAME_T;
               score_d = '0;
               level_d = '0;
               gap_d   = GAP_L;
            end
         end
         S_PLAY: begin
            if (tick) begin
               presc_d = '0;
               time_d  = time_q - TIME_W'(1);
            end else begin
               presc_d = presc_q + PRESC_W'(1);
            end

            if (pos_q == '0) begin
               // Blank gap: keys are ignored; spawn when the gap runs out.
               if (gap_q <= GAP_W'(1)) begin
                  pos_d      = spawn_hot;
                  life_d     = life_load;
                  prev_d     = sel_idx;
                  prev_vld_d = 1'b1;
               end else begin
                  gap_d = gap_q - GAP_W'(1);
               end
            end else if (key == pos_q) begin
               // Correct hit beats a simultaneous expiry.
               hit_d = 1'b1;
               if (score_q != '1) score_d = score_q + SCORE_W'(1);
               pos_d = '0;
               gap_d = GAP_L;
            end else begin
               if (key != '0) begin
                  miss_d = 1'b1;
                  if ((PENALTY != 0) && (score_q != '0)) score_d = score_q - SCORE_W'(1);
               end
               if (life_q <= LIFE_W'(1)) begin
                  miss_d = 1'b1;
                  pos_d  = '0;
                  gap_d  = GAP_L;
               end else begin
                  life_d = life_q - LIFE_W'(1);
               end
            end

            if (game_end) begin
               // A mole that would spawn on the final edge is never shown,
               // so it must not count as the previous hole either.
               time_d     = '0;
               pos_d      = '0;
               prev_d     = prev_q;
               prev_vld_d = prev_vld_q;
`ifdef HIGH_SCORE_EN
               best_d     = (score_d > best_q) ? score_d : best_q;
`endif
            end
         end
         default: ;
      endcase
   end

   // Datapath registers with asynchronous reset to idle values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lfsr_q     <= LFSR_SEED;
         start_q    <= 1'b0;
         presc_q    <= '0;
         time_q     <= GAME_T;
         score_q    <= '0;
         level_q    <= '0;
         pos_q      <= '0;
         gap_q      <= GAP_L;
         life_q     <= '0;
         prev_q     <= '0;
         prev_vld_q <= 1'b0;
         hit_q      <= 1'b0;
         miss_q     <= 1'b0;
`ifdef HIGH_SCORE_EN
         best_q     <= '0;
`endif
      end else begin
         lfsr_q     <= lfsr_d;
         start_q    <= start;
         presc_q    <= presc_d;
         time_q     <= time_d;
         score_q    <= score_d;
         level_q    <= level_d;
         pos_q      <= pos_d;
         gap_q      <= gap_d;
         life_q     <= life_d;
         prev_q     <= prev_d;
         prev_vld_q <= prev_vld_d;
         hit_q      <= hit_d;
         miss_q     <= miss_d;
`ifdef HIGH_SCORE_EN
         best_q     <= best_d;
`endif
      end
   end

   assign position = pos_q;
   assign cnttime  = time_q;
   assign score    = score_q;
   assign level    = level_q;
   assign hit      = hit_q;
   assign miss     = miss_q;
`ifdef HIGH_SCORE_EN
   assign best     = best_q;
`endif

endmodule

// File: tb/tb_mole_game_core.sv
// tb_mole_game_core: randomized self-checking bench for mole_game_core.
// A cycle-level game model (elapsed play cycles, spawn/expiry timestamps,
// score rules) predicts every output; the hole index itself comes from the
// DUT's LFSR and is checked only for being one-hot and not repeating.

module tb_mole_game_core;

   localparam int NH    = 16;
   localparam int SW    = 5;
   localparam int TW    = 6;
   localparam int GAME  = 30;
   localparam int TICK  = 10;
   localparam int MOLE  = 64;
   localparam int GAP   = 4;
   localparam int STEP  = 2;
   localparam int MAXL  = 3;
   localparam int SMAX  = 31;

   localparam int ST_IDLE = 0;
   localparam int ST_PLAY = 1;
   localparam int ST_OVER = 2;

   localparam int MD_ZERO  = 0;
   localparam int MD_HIT   = 1;
   localparam int MD_WRONG = 2;
   localparam int MD_LATE  = 3;
   localparam int MD_RAND  = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [NH-1:0] key;
   logic          start;
   logic [NH-1:0] position;
   logic [TW-1:0] cnttime;
   logic [SW-1:0] score;
   logic [1:0]    level;
   logic          playing, game_over, hit, miss;
`ifdef HIGH_SCORE_EN
   logic [SW-1:0] best;
`endif

   mole_game_core #(
      .N_HOLES(NH), .SCORE_W(SW), .TIME_W(TW), .GAME_SECONDS(GAME),
      .TICK_DIV(TICK), .MOLE_CYCLES(MOLE), .GAP_CYCLES(GAP),
      .LEVEL_STEP(STEP), .MAX_LEVEL(MAXL), .PENALTY(1)
   ) dut (
      .clk(clk), .rst(rst), .key(key), .start(start),
      .position(position), .cnttime(cnttime), .score(score), .level(level),
      .playing(playing), .game_over(game_over), .hit(hit), .miss(miss)
`ifdef HIGH_SCORE_EN
      , .best(best)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // behavioural game model
   int m_state, m_score, m_level, m_time, m_k, m_spawn, m_expire;
   int m_on, m_just, m_hole, m_prev, m_best, m_hit, m_miss, m_start_last;
   int mode;
   logic start_val;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int lvl(input int s);
      return (s / STEP > MAXL) ? MAXL : s / STEP;
   endfunction

   task automatic model_reset();
      m_state = ST_IDLE; m_score = 0; m_level = 0; m_time = GAME; m_k = 0;
      m_spawn = 0; m_expire = 0; m_on = 0; m_just = 0; m_hole = 0;
      m_prev = -1; m_best = 0; m_hit = 0; m_miss = 0; m_start_last = 0;
   endtask

   task automatic check_reset_values();
      chk("rst_position", 32'(position), 32'd0);
      chk("rst_cnttime", 32'(cnttime), 32'(GAME));
      chk("rst_score", 32'(score), 32'd0);
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_playing", 32'(playing), 32'd0);
      chk("rst_game_over", 32'(game_over), 32'd0);
      chk("rst_hit", 32'(hit), 32'd0);
      chk("rst_miss", 32'(miss), 32'd0);
`ifdef HIGH_SCORE_EN
      chk("rst_best", 32'(best), 32'd0);
`endif
   endtask

   // Compare every output against the model state after the last edge.
   task automatic check_outputs();
      int idx;
      chk("playing", 32'(playing), 32'(m_state == ST_PLAY));
      chk("game_over", 32'(game_over), 32'(m_state == ST_OVER));
      chk("cnttime", 32'(cnttime), 32'(m_time));
      chk("score", 32'(score), 32'(m_score));
      chk("level", 32'(level), 32'(m_level));
      chk("hit", 32'(hit), 32'(m_hit));
      chk("miss", 32'(miss), 32'(m_miss));
`ifdef HIGH_SCORE_EN
      chk("best", 32'(best), 32'(m_best));
`endif
      if (m_on == 0) begin
         chk("position_off", 32'(position), 32'd0);
      end else if (m_just != 0) begin
         idx = -1;
         for (int b = 0; b < NH; b++) if (position[b]) idx = b;
         chk("position_onehot", 32'($countones(position)), 32'd1);
         if (m_prev >= 0) chk("position_new_hole", 32'(idx != m_prev), 32'd1);
         m_hole = (idx < 0) ? 0 : idx;
         m_prev = m_hole;
         m_just = 0;
      end else begin
         chk("position_lit", 32'(position), 32'(16'(1) << m_hole));
      end
   endtask

   task automatic pick_key();
      logic [NH-1:0] good, wrong;
      int r;
      good  = 16'(1) << m_hole;
      wrong = 16'(1) << ((m_hole + 1 + $urandom_range(0, NH - 2)) % NH);
      key = '0;
      case (mode)
         MD_HIT:   if (m_on != 0) key = good;
         MD_WRONG: if (m_on != 0) key = wrong;
         MD_LATE:  if (m_on != 0 && m_expire == m_k + 1) key = good;
         MD_RAND: begin
            r = $urandom_range(0, 7);
            if (r <= 1 && m_on != 0) key = good;
            else if (r == 2) key = wrong;
            else if (r == 3) key = 16'($urandom());
            else if (r == 4) key = 16'(1) << $urandom_range(0, NH - 1);
         end
         default: key = '0;
      endcase
   endtask

   // Apply the game rules for one clock edge with the inputs just driven.
   task automatic model_edge();
      int old_score, k1;
      logic [NH-1:0] good;
      old_score = m_score;
      good = 16'(1) << m_hole;
      m_hit = 0;
      m_miss = 0;
      if (m_state == ST_PLAY) begin
         k1 = m_k + 1;
         if (m_on != 0) begin
            if (key == good) begin
               m_hit = 1;
               if (m_score < SMAX) m_score++;
               m_on = 0;
               m_spawn = k1 + GAP;
            end else begin
               if (key != '0) begin
                  m_miss = 1;
                  if (m_score > 0) m_score--;
               end
               if (k1 == m_expire) begin
                  m_miss = 1;
                  m_on = 0;
                  m_spawn = k1 + GAP;
               end
            end
         end else if (k1 == m_spawn) begin
            m_on = 1;
            m_just = 1;
            m_expire = k1 + (MOLE >> m_level);
         end
         m_level = lvl(old_score);
         m_k = k1;
         m_time = GAME - k1 / TICK;
         if (k1 == GAME * TICK) begin
            m_state = ST_OVER;
            m_on = 0;
            m_just = 0;
            m_time = 0;
            if (m_score > m_best) m_best = m_score;
         end
      end else begin
         if (start && m_start_last == 0) begin
            m_state = ST_PLAY;
            m_score = 0;
            m_level = 0;
            m_time = GAME;
            m_k = 0;
            m_on = 0;
            m_just = 0;
            m_spawn = GAP;
         end else begin
            m_level = lvl(old_score);
         end
      end
      m_start_last = int'(start);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check_outputs();
         start = start_val;
         pick_key();
         @(posedge clk);
         model_edge();
      end
   endtask

   task automatic run_to_over();
      if (m_state == ST_PLAY) run(GAME * TICK - m_k);
      run(6);
   endtask

   task automatic begin_game();
      start_val = 1'b1;
      run(3);
      start_val = 1'b0;
   endtask

   task automatic async_reset();
      @(negedge clk);
      #2;
      rst = 1'b0;
      key = '0;
      start = 1'b0;
      start_val = 1'b0;
      #1;
      check_reset_values();
      model_reset();
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      rst = 1'b0;
      key = '0;
      start = 1'b0;
      start_val = 1'b0;
      mode = MD_ZERO;
      model_reset();
      repeat (2) @(negedge clk);
      check_reset_values();
      rst = 1'b1;
      run(3);

      // game 1: hits, level-1 lifetime expiry, ignored start, wrong keys, late hits
      begin_game();
      mode = MD_HIT;   run(14);
      mode = MD_ZERO;  run(40);
      start_val = 1'b1; run(5); start_val = 1'b0;
      run(30);
      mode = MD_WRONG; run(12);
      mode = MD_LATE;  run(90);
      mode = MD_RAND;  run(40);
      run_to_over();

      // game 2: hit every mole to reach saturation and the top level
      mode = MD_HIT;
      begin_game();
      run_to_over();

      // game 3: lower score, best must hold the earlier maximum
      begin_game();
      mode = MD_HIT;   run(25);
      mode = MD_RAND;  run(60);
      run_to_over();

      // game 4: asynchronous reset in the middle of play
      begin_game();
      mode = MD_HIT;   run(37);
      async_reset();
      run(3);

      // game 5: random play after reset, running to the end
      begin_game();
      mode = MD_RAND;  run(100);
      mode = MD_LATE;  run(50);
      run_to_over();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
